// File: rtl/sp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sp_pkg : shared state codes and sizing helpers for sp_sweep_tracker      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sp_pkg;

  localparam int STAT_W = 3;

  localparam logic [STAT_W-1:0] STAT_IDLE   = 3'd0;
  localparam logic [STAT_W-1:0] STAT_SETTLE = 3'd1;
  localparam logic [STAT_W-1:0] STAT_SAMPLE = 3'd2;
  localparam logic [STAT_W-1:0] STAT_STEP   = 3'd3;
  localparam logic [STAT_W-1:0] STAT_PARK   = 3'd4;
  localparam logic [STAT_W-1:0] STAT_NEXT   = 3'd5;

  typedef enum logic [STAT_W-1:0] {
    ST_IDLE   = STAT_IDLE,
    ST_SETTLE = STAT_SETTLE,
    ST_SAMPLE = STAT_SAMPLE,
    ST_STEP   = STAT_STEP,
    ST_PARK   = STAT_PARK,
    ST_NEXT   = STAT_NEXT
  } sp_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int sp_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_sweep_tracker_pwm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | servo_pwm_ch : one servo PWM channel driven from the shared frame counter|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module servo_pwm_ch import sp_pkg::*; #(
  parameter int CNT_W   = 21,
  parameter int POS_W   = 21,
  parameter int RST_CMP = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wrap,
  input  logic [POS_W-1:0] pos,
  output logic             servo
);

  localparam int CMP_W = (CNT_W > POS_W) ? CNT_W : POS_W;

  logic [POS_W-1:0] r_cmp;
  logic             r_servo;
  logic [CMP_W-1:0] w_cnt_x;
  logic [CMP_W-1:0] w_cmp_x;

  assign w_cnt_x = CMP_W'(cnt);
  assign w_cmp_x = CMP_W'(r_cmp);

  // cmp only reloads at the frame boundary so a mid-frame move never cuts a pulse short.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cmp   <= POS_W'(RST_CMP);
      r_servo <= 1'b0;
    end else begin
      if (wrap) r_cmp <= pos;
      r_servo <= (w_cnt_x < w_cmp_x);
    end
  end

  assign servo = r_servo;

endmodule
`default_nettype wire

// File: rtl/sp_sweep_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sp_sweep_tracker : multi-axis servo sweep that parks each axis at the    |
// | position giving the highest panel voltage; manual jog when idle.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sp_sweep_tracker import sp_pkg::*; #(
  parameter int NUM_AXES   = 2,
  parameter int ADC_W      = 12,
  parameter int POS_W      = 21,
  parameter int PERIOD     = 2_000_000,
  parameter int POS_MIN    = 100_000,
  parameter int POS_MAX    = 200_000,
  parameter int POS_STEP   = 10_000,
  parameter int SETTLE_PER = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      MODE,
  input  logic                      START,
  input  logic [NUM_AXES-1:0]       JOG_INC,
  input  logic [NUM_AXES-1:0]       JOG_DEC,
  input  logic [ADC_W-1:0]          ADC_DATA,
  input  logic                      ADC_VALID,
  output logic [NUM_AXES-1:0]       SERVO,
  output logic [NUM_AXES*POS_W-1:0] POS,
  output logic [ADC_W-1:0]          MAX_V,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [STAT_W-1:0]         STAT
);

  localparam int CNT_W = sp_cnt_w(PERIOD);
  localparam int AX_W  = sp_cnt_w(NUM_AXES);
  localparam int SET_W = sp_cnt_w(SETTLE_PER);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PERIOD - 1);
  localparam logic [SET_W-1:0] c_set_last = SET_W'(SETTLE_PER - 1);
  localparam logic [AX_W-1:0]  c_ax_last  = AX_W'(NUM_AXES - 1);
  localparam logic [POS_W:0]   c_pos_min  = (POS_W+1)'(POS_MIN);
  localparam logic [POS_W:0]   c_pos_max  = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]   c_pos_step = (POS_W+1)'(POS_STEP);

  sp_state_t                          r_state;
  sp_state_t                          w_state_nx;
  logic [CNT_W-1:0]                   r_cnt;
  logic                               w_wrap;
  logic [NUM_AXES-1:0][POS_W-1:0]     r_pos;
  logic [NUM_AXES-1:0][POS_W-1:0]     w_jog;
  logic [AX_W-1:0]                    r_axis;
  logic [AX_W-1:0]                    w_axis_nx;
  logic [POS_W-1:0]                   r_best;
  logic [ADC_W-1:0]                   r_max_v;
  logic [SET_W-1:0]                   r_settle;
  logic                               r_park_exit;
  logic [POS_W:0]                     w_step_sum;
  logic                               w_step_over;
  logic                               w_settle_done;
  logic                               w_last_axis;

  assign w_wrap        = (r_cnt == c_cnt_last);
  assign w_settle_done = w_wrap && (r_settle == c_set_last);
  assign w_last_axis   = (r_axis == c_ax_last);
  assign w_axis_nx     = r_axis + AX_W'(1);
  // One extra bit so a step past POS_MAX near the top of the range cannot wrap.
  assign w_step_sum    = {1'b0, r_pos[r_axis]} + c_pos_step;
  assign w_step_over   = (w_step_sum > c_pos_max);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else r_cnt <= r_cnt + CNT_W'(1);
  end

  for (genvar k = 0; k < NUM_AXES; k++) begin : g_axis
    logic [POS_W:0]   w_up_sum;
    logic [POS_W-1:0] w_up;
    logic [POS_W-1:0] w_dn;

    assign w_up_sum = {1'b0, r_pos[k]} + c_pos_step;
    assign w_up     = (w_up_sum > c_pos_max) ? c_pos_max[POS_W-1:0] : w_up_sum[POS_W-1:0];
    assign w_dn     = ({1'b0, r_pos[k]} < (c_pos_min + c_pos_step)) ?
                      c_pos_min[POS_W-1:0] : (r_pos[k] - c_pos_step[POS_W-1:0]);
    assign w_jog[k] = (JOG_INC[k] && !JOG_DEC[k]) ? w_up :
                      (JOG_DEC[k] && !JOG_INC[k]) ? w_dn : r_pos[k];

    assign POS[k*POS_W +: POS_W] = r_pos[k];

    servo_pwm_ch #(
      .CNT_W  (CNT_W),
      .POS_W  (POS_W),
      .RST_CMP(POS_MIN)
    ) u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .cnt  (r_cnt),
      .wrap (w_wrap),
      .pos  (r_pos[k]),
      .servo(SERVO[k])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:   if (MODE && START) w_state_nx = ST_SETTLE;
      ST_SETTLE: if (w_settle_done) w_state_nx = r_park_exit ? ST_NEXT : ST_SAMPLE;
      ST_SAMPLE: if (ADC_VALID) w_state_nx = ST_STEP;
      ST_STEP:   w_state_nx = w_step_over ? ST_PARK : ST_SETTLE;
      ST_PARK:   w_state_nx = ST_SETTLE;
      ST_NEXT:   w_state_nx = w_last_axis ? ST_IDLE : ST_SETTLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (r_state != ST_IDLE);
    DONE = (r_state == ST_NEXT) && w_last_axis;
    STAT = r_state;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < NUM_AXES; k++) r_pos[k] <= c_pos_min[POS_W-1:0];
      r_axis      <= '0;
      r_best      <= c_pos_min[POS_W-1:0];
      r_max_v     <= '0;
      r_settle    <= '0;
      r_park_exit <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (MODE) begin
            if (START) begin
              r_axis      <= '0;
              r_pos[0]    <= c_pos_min[POS_W-1:0];
              r_best      <= c_pos_min[POS_W-1:0];
              r_max_v     <= '0;
              r_settle    <= '0;
              r_park_exit <= 1'b0;
            end
          end else begin
            r_pos <= w_jog;
          end
        end
        ST_SETTLE: if (w_wrap) r_settle <= w_settle_done ? '0 : r_settle + SET_W'(1);
        // Strict compare: on a tie the earlier position is kept.
        ST_SAMPLE: begin
          if (ADC_VALID && (ADC_DATA > r_max_v)) begin
            r_max_v <= ADC_DATA;
            r_best  <= r_pos[r_axis];
          end
        end
        ST_STEP: if (!w_step_over) r_pos[r_axis] <= w_step_sum[POS_W-1:0];
        ST_PARK: begin
          r_pos[r_axis] <= r_best;
          r_park_exit   <= 1'b1;
        end
        ST_NEXT: begin
          r_park_exit <= 1'b0;
          if (!w_last_axis) begin
            r_axis           <= w_axis_nx;
            r_pos[w_axis_nx] <= c_pos_min[POS_W-1:0];
            r_best           <= c_pos_min[POS_W-1:0];
            r_max_v          <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign MAX_V = r_max_v;

endmodule
`default_nettype wire

// File: tb/tb_sp_sweep_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sp_sweep_tracker : self-checking bench for sp_sweep_tracker           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sp_sweep_tracker;

  localparam int NA    = 2;
  localparam int AW    = 12;
  localparam int PW    = 21;
  localparam int PER   = 100;
  localparam int PMIN  = 10;
  localparam int PMAX  = 50;
  localparam int PSTEP = 10;
  localparam int SET   = 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          MODE = 1'b0;
  logic          START = 1'b0;
  logic [NA-1:0] JOG_INC = '0;
  logic [NA-1:0] JOG_DEC = '0;
  logic [AW-1:0] ADC_DATA = '0;
  logic          ADC_VALID = 1'b0;
  wire  [NA-1:0]    SERVO;
  wire  [NA*PW-1:0] POS;
  wire  [AW-1:0]    MAX_V;
  wire              BUSY;
  wire              DONE;
  wire  [2:0]       STAT;

  sp_sweep_tracker #(
    .NUM_AXES(NA), .ADC_W(AW), .POS_W(PW), .PERIOD(PER),
    .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_STEP(PSTEP), .SETTLE_PER(SET)
  ) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .START(START),
    .JOG_INC(JOG_INC), .JOG_DEC(JOG_DEC), .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID),
    .SERVO(SERVO), .POS(POS), .MAX_V(MAX_V), .BUSY(BUSY), .DONE(DONE), .STAT(STAT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int posk(input int k);
    return int'(POS[k*PW +: PW]);
  endfunction

  // Panel voltage seen by the bench's ADC for a given axis/position.
  function automatic int adc_val(input int ax, input int p);
    if (ax != 0) return 500;
    case ((p - PMIN) / PSTEP)
      0: return 100;
      1: return 300;
      2: return 900;
      3: return 900;
      default: return 200;
    endcase
  endfunction

  // Behavioural model state
  int m_pos [NA];
  bit m_track = 1'b0;
  bit chk_en  = 1'b0;
  int done_cnt = 0;
  bit done_prev = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      done_prev = 1'b0;
    end else if (chk_en) begin
      chk("busy_vs_stat", int'(BUSY), int'(STAT != 3'd0));
      if (done_prev) chk("busy_after_done", int'(BUSY), 0);
      if (DONE) chk("done_in_next", int'(STAT), 5);
      if (m_track) for (int k = 0; k < NA; k++) chk("pos_model", posk(k), m_pos[k]);
      done_prev = DONE;
      if (DONE) done_cnt++;
    end
  end

  // PWM pulse-length recorder
  int cyc = 0;
  int hc0 = 0, hc1 = 0;
  int pq0[$];
  int pq1[$];
  int rise0[$];
  bit sp0 = 1'b0;

  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      hc0 = 0; hc1 = 0; sp0 = 1'b0;
    end else begin
      if (SERVO[0]) begin
        if (!sp0) rise0.push_back(cyc);
        hc0++;
      end else if (hc0 != 0) begin
        pq0.push_back(hc0); hc0 = 0;
      end
      sp0 = SERVO[0];
      if (SERVO[1]) hc1++;
      else if (hc1 != 0) begin
        pq1.push_back(hc1); hc1 = 0;
      end
    end
  end

  // ADC responder: answers one cycle into SAMPLE, and spams a bogus sample during SETTLE.
  bit adc_en = 1'b0;
  int samp_limit = 0;
  int n_samp = 0;
  int sw_axis = 0;
  bit samp_wait = 1'b0;
  int prev_stat = 0;
  int seen[$];
  bit got_ax0 = 1'b0;
  int mv_ax0 = 0, pos_ax0 = 0;

  always @(negedge CLK) begin
    ADC_VALID = 1'b0;
    if (!RST) begin
      sw_axis = 0; samp_wait = 1'b0; prev_stat = 0;
    end else begin
      if (STAT == 3'd0) sw_axis = 0;
      if (STAT == 3'd5 && prev_stat != 5) begin
        if (sw_axis == 0 && !got_ax0) begin
          got_ax0 = 1'b1; mv_ax0 = int'(MAX_V); pos_ax0 = posk(0);
        end
        sw_axis++;
      end
      if (STAT != 3'd2) samp_wait = 1'b0;
      if (adc_en) begin
        if (STAT == 3'd1) begin
          ADC_VALID = 1'b1; ADC_DATA = 12'd4000;
        end else if (STAT == 3'd2) begin
          if (!samp_wait) samp_wait = 1'b1;
          else if (n_samp < samp_limit) begin
            ADC_VALID = 1'b1;
            ADC_DATA  = AW'(adc_val(sw_axis, posk(sw_axis)));
            seen.push_back(posk(sw_axis));
            n_samp++;
            samp_wait = 1'b0;
          end
        end
      end
      prev_stat = int'(STAT);
    end
  end

  task automatic jog(input logic [NA-1:0] inc, input logic [NA-1:0] dec);
    @(negedge CLK); JOG_INC = inc; JOG_DEC = dec;
    @(posedge CLK); #1;
    for (int k = 0; k < NA; k++) begin
      if (inc[k] && !dec[k]) m_pos[k] = (m_pos[k] + PSTEP > PMAX) ? PMAX : m_pos[k] + PSTEP;
      else if (dec[k] && !inc[k]) m_pos[k] = (m_pos[k] - PSTEP < PMIN) ? PMIN : m_pos[k] - PSTEP;
    end
    @(negedge CLK); JOG_INC = '0; JOG_DEC = '0;
  endtask

  task automatic wait_rise(input string nm);
    int n = 0;
    bit p = SERVO[0];
    while (n < 300) begin
      @(negedge CLK); n++;
      if (SERVO[0] && !p) break;
      p = SERVO[0];
    end
    chk(nm, int'(n < 300), 1);
  endtask

  task automatic wait_pulses(input int cnt, input string nm);
    int n = 0;
    while (pq0.size() < cnt && n < 400) begin
      @(negedge CLK); n++;
    end
    chk(nm, pq0.size() >= cnt ? 1 : 0, 1);
  endtask

  int exp_seq[$];
  int m_park [NA];
  int m_max  [NA];

  initial begin
    int n, d0;
    for (int k = 0; k < NA; k++) m_pos[k] = PMIN;

    // Reset state
    repeat (4) @(negedge CLK);
    #1;
    chk("rst_stat", int'(STAT), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_maxv", int'(MAX_V), 0);
    chk("rst_servo", int'(SERVO), 0);
    chk("rst_pos0", posk(0), 10);
    chk("rst_pos1", posk(1), 10);
    @(negedge CLK); RST = 1'b1;
    chk_en = 1'b1; m_track = 1'b1;
    repeat (320) @(negedge CLK);
    chk("rst_pulse_cnt", int'(pq0.size() >= 3), 1);
    chk("rst_pulse0", pq0[pq0.size()-1], 10);
    chk("rst_pulse0b", pq0[pq0.size()-2], 10);
    chk("rst_pulse1", pq1[pq1.size()-1], 10);
    chk("rst_frame", rise0[rise0.size()-1] - rise0[rise0.size()-2], 100);

    // Manual jog
    repeat (5) jog(2'b01, 2'b00);
    chk("jog_sat_max", posk(0), 50);
    jog(2'b10, 2'b10);
    chk("jog_both", posk(1), 10);
    jog(2'b00, 2'b10);
    chk("jog_sat_min", posk(1), 10);
    jog(2'b10, 2'b00);
    chk("jog_inc1", posk(1), 20);
    jog(2'b00, 2'b10);

    // START ignored in manual mode
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (5) @(negedge CLK);
    chk("start_manual_stat", int'(STAT), 0);

    // Glitch-free PWM: mid-frame moves take effect next frame
    repeat (4) jog(2'b00, 2'b01);
    wait_rise("rise_a");
    pq0.delete();
    repeat (38) @(negedge CLK);
    jog(2'b01, 2'b00);
    wait_pulses(2, "pulses_a");
    chk("glitch_cur10", pq0[0], 10);
    chk("glitch_next20", pq0[1], 20);
    wait_rise("rise_b");
    pq0.delete();
    repeat (3) @(negedge CLK);
    jog(2'b00, 2'b01);
    wait_pulses(2, "pulses_b");
    chk("glitch_cur20", pq0[0], 20);
    chk("glitch_next10", pq0[1], 10);

    // Model of the sweep outcome
    for (int ax = 0; ax < NA; ax++) begin
      int mv, bp;
      mv = 0; bp = PMIN;
      for (int p = PMIN; p <= PMAX; p += PSTEP) begin
        exp_seq.push_back(p);
        if (adc_val(ax, p) > mv) begin mv = adc_val(ax, p); bp = p; end
      end
      m_park[ax] = bp; m_max[ax] = mv;
    end

    // Auto sweep with ignored inputs injected while busy
    m_track = 1'b0;
    seen.delete(); n_samp = 0; samp_limit = 99; adc_en = 1'b1; got_ax0 = 1'b0;
    d0 = done_cnt;
    @(negedge CLK); MODE = 1'b1; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (30) @(negedge CLK);
    MODE = 1'b0; JOG_INC = 2'b11; START = 1'b1;
    @(negedge CLK); JOG_INC = '0; START = 1'b0; MODE = 1'b1;
    @(negedge CLK); MODE = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 5000) begin @(negedge CLK); n++; end
    repeat (3) @(negedge CLK);
    chk("sweep_done_once", done_cnt - d0, 1);
    chk("sweep_park0", posk(0), 30);
    chk("sweep_park1", posk(1), 10);
    chk("sweep_maxv", int'(MAX_V), 500);
    chk("sweep_park0_model", posk(0), m_park[0]);
    chk("sweep_park1_model", posk(1), m_park[1]);
    chk("sweep_maxv_model", int'(MAX_V), m_max[NA-1]);
    chk("ax0_maxv", mv_ax0, 900);
    chk("ax0_maxv_model", mv_ax0, m_max[0]);
    chk("ax0_park", pos_ax0, m_park[0]);
    chk("sweep_nsamp", seen.size(), exp_seq.size());
    for (int i = 0; i < seen.size() && i < exp_seq.size(); i++) chk("sweep_seq", seen[i], exp_seq[i]);
    repeat (20) @(negedge CLK);
    chk("idle_after_sweep", int'(STAT), 0);
    m_pos[0] = m_park[0]; m_pos[1] = m_park[1];
    m_track = 1'b1;

    // Reset in the middle of a sweep
    m_track = 1'b0;
    seen.delete(); n_samp = 0; samp_limit = 2;
    @(negedge CLK); MODE = 1'b1; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    n = 0;
    while (!(n_samp == 2 && STAT == 3'd2) && n < 2000) begin @(negedge CLK); n++; end
    chk("mid_stat_sample", int'(STAT), 2);
    chk("mid_pos0", posk(0), 30);
    chk("mid_maxv", int'(MAX_V), 300);
    d0 = done_cnt;
    RST = 1'b0;
    #1;
    chk("mid_rst_stat", int'(STAT), 0);
    chk("mid_rst_busy", int'(BUSY), 0);
    chk("mid_rst_done", int'(DONE), 0);
    chk("mid_rst_maxv", int'(MAX_V), 0);
    chk("mid_rst_pos0", posk(0), 10);
    chk("mid_rst_pos1", posk(1), 10);
    chk("mid_rst_servo", int'(SERVO), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    adc_en = 1'b0;
    m_pos[0] = PMIN; m_pos[1] = PMIN; m_track = 1'b1;
    repeat (200) @(negedge CLK);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_idle", int'(STAT), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sp_sweep_tracker.md
# sp_sweep_tracker

Parametrised multi-axis successor to the two-servo solar-panel optimizer: drives `NUM_AXES` hobby-servo PWM outputs and, on command, sweeps each axis in turn across a position range, sampling panel voltage at every step and parking the axis at the best position found. It sits between the ADC front end (XADC wrapper) and the servo pins. It also replaces the button jog path with a per-axis manual mode.

## Interface
- `NUM_AXES`, 2: number of servo axes swept in index order 0..N-1
- `ADC_W`, 12: sample width
- `POS_W`, 21: position/pulse-width width, in CLK ticks
- `PERIOD`, 2_000_000: PWM frame length in ticks (20 ms at 100 MHz)
- `POS_MIN`, 100_000; `POS_MAX`, 200_000; `POS_STEP`, 10_000: pulse-width range and step, in ticks
- `SETTLE_PER`, 3: PWM frames to wait after every position change before sampling

- `CLK` in 1: sole clock
- `RST` in 1: asynchronous, active-low reset
- `MODE` in 1: 1 = auto sweep, 0 = manual jog; sampled only in IDLE
- `START` in 1: single-cycle pulse that begins a sweep (MODE=1, IDLE only)
- `JOG_INC`, `JOG_DEC` in NUM_AXES: debounced single-cycle jog pulses per axis
- `ADC_DATA` in ADC_W: panel voltage sample
- `ADC_VALID` in 1: ADC_DATA valid this cycle
- `SERVO` out NUM_AXES: PWM outputs
- `POS` out NUM_AXES*POS_W: current commanded positions, axis k at `[k*POS_W +: POS_W]`
- `MAX_V` out ADC_W: best sample of the axis being or last swept
- `BUSY` out 1: high in every state except IDLE
- `DONE` out 1: one-cycle pulse at sweep completion
- `STAT` out 3: state code

## Operation
- States/STAT codes: IDLE=0, SETTLE=1, SAMPLE=2, STEP=3, PARK=4, NEXT=5.
- IDLE + START + MODE=1:
  - Set axis=0, pos[0]=POS_MIN, best=POS_MIN, MAX_V=0.
  - Go to SETTLE.
- SETTLE:
  - Count PWM frame wraps.
  - After SETTLE_PER wraps, go to SAMPLE, or return to the state recorded on entry (PARK exit path).
- SAMPLE:
  - Wait for ADC_VALID and capture the first valid sample.
  - If ADC_DATA > MAX_V (strict; ties keep the earlier position): MAX_V=ADC_DATA, best=pos[axis].
  - Go to STEP.
- STEP:
  - If pos[axis]+POS_STEP > POS_MAX, go to PARK.
  - Else pos[axis]+=POS_STEP and go to SETTLE.
- PARK: pos[axis]=best, then SETTLE; the settle exit leads to NEXT.
- NEXT:
  - If axis==NUM_AXES-1: pulse DONE and go to IDLE.
  - Else axis++, pos[axis]=POS_MIN, best=POS_MIN, MAX_V=0, go to SETTLE.
- Manual (IDLE, MODE=0):
  - JOG_INC[k] adds POS_STEP to pos[k], saturating at POS_MAX.
  - JOG_DEC[k] subtracts POS_STEP from pos[k], saturating at POS_MIN.
  - Both pulses in the same cycle: no change.
  - Axes are independent.
- Ignored inputs:
  - START when MODE=0 or BUSY.
  - Jogs when BUSY or MODE=1.
  - ADC_VALID outside SAMPLE.
  - MODE changes while BUSY.
- Arithmetic: positions compared in POS_W+1 bits, so overflow cannot wrap.

## Timing
- Reset values: all pos=POS_MIN, MAX_V=0, BUSY=0, DONE=0, STAT=0, axis=0, frame counter=0, SERVO=0.
- PWM:
  - Frame counter cnt runs 0..PERIOD-1 and wraps.
  - SERVO[k] = (cnt < cmp[k]), registered, one-cycle output latency.
  - cmp[k] loads from pos[k] only on the cycle cnt wraps to 0. A position change takes effect in the next frame; no runt pulses.
- Sweep latency per step ≈ SETTLE_PER frames + ADC wait + 2 cycles.
- Steps per axis = floor((POS_MAX-POS_MIN)/POS_STEP)+1.
- Jog: pos updates the cycle after the pulse.
- DONE is asserted in the NEXT→IDLE cycle; BUSY falls on the following cycle.
- Reset asserted mid-sweep: immediate return to reset values, with no DONE.

## Structure
- Shared package `sp_pkg`: state enum, STAT codes, and a `clog2`-based counter-width constant for PERIOD.
- Sub-module `servo_pwm_ch`, one instance per axis via generate. It holds the cmp register and the registered output, and takes the shared cnt and wrap strobe as inputs.

## Test plan
Bench parameters: PERIOD=100, POS_MIN=10, POS_MAX=50, POS_STEP=10, SETTLE_PER=1, NUM_AXES=2.

- Reset: hold RST=0 then release → SERVO high exactly 10 cycles per 100-cycle frame, POS={10,10}, STAT=0.
- Manual: MODE=0, 5×JOG_INC[0] → pos[0]=50 (saturated). Then JOG_INC[1] and JOG_DEC[1] in the same cycle → pos[1]=10 unchanged.
- Auto sweep:
  - Stimulus: ADC returns 100,300,900,900,200 for positions 10..50 on axis 0, and 500 flat on axis 1.
  - Required: axis 0 parks at 30 (tie keeps earlier), axis 1 parks at 10, MAX_V=500, DONE pulses once, BUSY falls one cycle later.
- Glitch-free PWM: jog pos[0] 10→20 at cnt=40 → the current frame still shows a 10-cycle high, the next frame 20.
- Reset mid-sweep: assert RST while STAT=2 → outputs return to reset values and no DONE is seen.
- Ignored inputs: START with MODE=0, ADC_VALID while in SETTLE, and MODE toggled while BUSY → no state or value effect.
